mc_calculator: RTL and testbench

Parametrised multi-cycle successor to the single-cycle simple calculator: a REGS×WIDTH register file, a single-cycle ALU, and a sequential shift-add multiplier. It executes in hardware the multiply sequence that otherwise takes software dozens of mask, shift and add steps. It sits as the datapath core of the calculator subsystem, driven cycle-by-cycle by a controller or testbench.

---
 rtl/calc_pkg.sv | 27 ++
 rtl/calc_alu.sv | 40 ++++
 rtl/mc_calculator.sv | 167 ++++++++++++++++
 tb/tb_mc_calculator.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the multi-cycle calculator: ALU opcodes and the
// multiplier sequencer state type.
package calc_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_PSX = 4'b0110;
    localparam logic [3:0] OP_PSY = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRA = 4'b1001;
    localparam logic [3:0] OP_ROL = 4'b1010;
    localparam logic [3:0] OP_ROR = 4'b1011;
    localparam logic [3:0] OP_EQ  = 4'b1100;
    localparam logic [3:0] OP_LT  = 4'b1101;
    localparam logic [3:0] OP_MUL = 4'b1110;
    localparam logic [3:0] OP_NOP = 4'b1111;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } calc_state_t;

endpackage

// File: rtl/calc_alu.sv
// Single-cycle combinational ALU. MUL and NOP both yield 0 here; the
// multi-cycle multiply is sequenced by the top module.
module calc_alu #(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] result,
    output logic             carry
);
    import calc_pkg::*;

    // Opcode decode; carry is only meaningful for ADD (carry-out) and SUB (borrow)
    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (ctrl)
            OP_ADD: {carry, result} = {1'b0, x} + {1'b0, y};
            OP_SUB: begin
                result = x - y;
                carry  = (x < y);
            end
            OP_AND: result = x & y;
            OP_OR:  result = x | y;
            OP_XOR: result = x ^ y;
            OP_NOT: result = ~x;
            OP_PSX: result = x;
            OP_PSY: result = y;
            OP_SLL: result = {x[WIDTH-2:0], 1'b0};
            OP_SRA: result = {x[WIDTH-1], x[WIDTH-1:1]};
            OP_ROL: result = {x[WIDTH-2:0], x[WIDTH-1]};
            OP_ROR: result = {x[0], x[WIDTH-1:1]};
            OP_EQ:  result = {{(WIDTH-1){1'b0}}, (x == y)};
            OP_LT:  result = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mc_calculator.sv
// Multi-cycle calculator datapath: REGS x WIDTH register file (R0 reads 0),
// single-cycle ALU and an optional sequential shift-add multiplier.
// Build option: define CALC_MUL_EN to include the multiplier; without it
// opcode MUL behaves as NOP and Busy/Done are tied low.
//
// state | meaning
// IDLE  | accepting writes; a MUL write captures operands and starts
// RUN   | one shift-add step per cycle, WEN ignored; last step writes result
module mc_calculator #(
    parameter  int WIDTH = 8,
    parameter  int REGS  = 8,
    localparam int AW    = $clog2(REGS)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             WEN,
    input  logic [AW-1:0]    RW,
    input  logic [AW-1:0]    RX,
    input  logic [AW-1:0]    RY,
    input  logic [WIDTH-1:0] DataIn,
    input  logic             Sel,
    input  logic [3:0]       Ctrl,
    output logic [WIDTH-1:0] busY,
    output logic             Carry,
    output logic             Busy,
    output logic             Done
);
    import calc_pkg::*;

    logic [WIDTH-1:0] regs [REGS];
    logic [WIDTH-1:0] rx_val, ry_val;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             accept;
    logic             mul_start;
    logic             mul_last;
    logic [AW-1:0]    mul_dst;
    logic [WIDTH-1:0] mul_data;
    logic             mul_ovf;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             carry_en;
    logic             carry_val;

    assign rx_val = regs[RX];
    assign ry_val = regs[RY];
    assign busY   = ry_val;
    assign accept = WEN & ~Busy;

    calc_alu #(.WIDTH(WIDTH)) u_alu (
        .ctrl   (Ctrl),
        .x      (rx_val),
        .y      (ry_val),
        .result (alu_result),
        .carry  (alu_carry)
    );

`ifdef CALC_MUL_EN
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    calc_state_t        state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic               done_q;

    assign mul_start = accept & Sel & (Ctrl == OP_MUL);
    assign acc_next  = mplier[0] ? (acc + mcand) : acc;
    assign mul_last  = (state == RUN) && (cnt == CW'(WIDTH - 1));
    assign mul_data  = acc_next[WIDTH-1:0];
    assign mul_ovf   = |acc_next[2*WIDTH-1:WIDTH];
    assign Busy      = (state == RUN);
    assign Done      = done_q;

    // Multiplier sequencer: operands are captured at start so later RX/RY/RW
    // changes and register writes cannot disturb the product
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            mul_dst <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= mul_last;
            case (state)
                IDLE: begin
                    if (mul_start) begin
                        mcand   <= {{WIDTH{1'b0}}, rx_val};
                        mplier  <= ry_val;
                        acc     <= '0;
                        cnt     <= '0;
                        mul_dst <= RW;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (mul_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign mul_start = 1'b0;
    assign mul_last  = 1'b0;
    assign mul_dst   = '0;
    assign mul_data  = '0;
    assign mul_ovf   = 1'b0;
    assign Busy      = 1'b0;
    assign Done      = 1'b0;
`endif

    // Select the single write port source: multiply completion wins, since
    // external writes are blocked while Busy anyway
    always_comb begin
        wr_en     = 1'b0;
        wr_addr   = RW;
        wr_data   = DataIn;
        carry_en  = 1'b0;
        carry_val = 1'b0;
        if (mul_last) begin
            wr_en     = (mul_dst != '0);
            wr_addr   = mul_dst;
            wr_data   = mul_data;
            carry_en  = 1'b1;
            carry_val = mul_ovf;
        end else if (accept && !mul_start) begin
            wr_en     = (RW != '0);
            wr_data   = Sel ? alu_result : DataIn;
            carry_en  = Sel;
            carry_val = alu_carry;
        end
    end

    // Register file; R0 is never written so it always reads zero
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Carry flag: updated by ALU writes and multiply completion, held otherwise
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Carry <= 1'b0;
        end else if (carry_en) begin
            Carry <= carry_val;
        end
    end

endmodule

// File: tb/tb_mc_calculator.sv
// Self-checking bench for mc_calculator. A behavioural model (integer
// arithmetic, product computed as x*y) is stepped on every rising edge and
// compared against the DUT one time unit later. Honours CALC_MUL_EN.
module tb_mc_calculator;
    localparam int W  = 8;
    localparam int N  = 8;
    localparam int AW = 3;
    localparam int M  = 1 << W;
`ifdef CALC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b1;
    logic          WEN = 1'b0;
    logic [AW-1:0] RW = '0, RX = '0, RY = '0;
    logic [W-1:0]  DataIn = '0;
    logic          Sel = 1'b0;
    logic [3:0]    Ctrl = '0;
    logic [W-1:0]  busY;
    logic          Carry, Busy, Done;

    mc_calculator #(.WIDTH(W), .REGS(N)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .WEN(WEN), .RW(RW), .RX(RX), .RY(RY),
        .DataIn(DataIn), .Sel(Sel), .Ctrl(Ctrl),
        .busY(busY), .Carry(Carry), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_fail = 0;

    int mregs [N];
    int mcarry, mleft, mdst, mprod;
    bit mbusy, mdone;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sx(input int v);
        return (v >= M / 2) ? v - M : v;
    endfunction

    function automatic int m_res(input int op, input int x, input int y);
        case (op)
            0:  return (x + y) % M;
            1:  return (x - y + M) % M;
            2:  return x & y;
            3:  return x | y;
            4:  return x ^ y;
            5:  return M - 1 - x;
            6:  return x;
            7:  return y;
            8:  return (2 * x) % M;
            9:  return x / 2 + ((x >= M / 2) ? M / 2 : 0);
            10: return (2 * x) % M + x / (M / 2);
            11: return x / 2 + (x % 2) * (M / 2);
            12: return (x == y) ? 1 : 0;
            13: return (sx(x) < sx(y)) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int m_car(input int op, input int x, input int y);
        if (op == 0) return (x + y >= M) ? 1 : 0;
        if (op == 1) return (x < y) ? 1 : 0;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) mregs[i] = 0;
        mcarry = 0; mbusy = 0; mdone = 0; mleft = 0; mdst = 0; mprod = 0;
    endtask

    task automatic model_step();
        int x, y, op, r;
        if (!Rst_n) begin
            model_reset();
            return;
        end
        x  = mregs[int'(RX)];
        y  = mregs[int'(RY)];
        op = int'(Ctrl);
        mdone = 0;
        if (mbusy) begin
            mleft--;
            if (mleft == 0) begin
                if (mdst != 0) mregs[mdst] = mprod % M;
                mcarry = (mprod >= M) ? 1 : 0;
                mbusy  = 0;
                mdone  = 1;
            end
        end else if (WEN) begin
            if (Sel && op == 14 && MUL_EN) begin
                mprod = x * y;
                mdst  = int'(RW);
                mleft = W;
                mbusy = 1;
            end else begin
                r = Sel ? m_res(op, x, y) : int'(DataIn);
                if (RW != 0) mregs[int'(RW)] = r;
                if (Sel) mcarry = m_car(op, x, y);
            end
        end
    endtask

    task automatic compare_all();
        chk("busY", int'(busY), mregs[int'(RY)]);
        chk("Carry", int'(Carry), mcarry);
        chk("Busy", int'(Busy), int'(mbusy));
        chk("Done", int'(Done), int'(mdone));
    endtask

    task automatic step();
        @(posedge Clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic wr(input int rw, input int d);
        WEN = 1'b1; Sel = 1'b0; RW = AW'(rw); DataIn = W'(d);
        step();
        WEN = 1'b0;
    endtask

    task automatic alu(input int rw, input int rx, input int ry, input int op);
        WEN = 1'b1; Sel = 1'b1; RW = AW'(rw); RX = AW'(rx); RY = AW'(ry); Ctrl = 4'(op);
        step();
        WEN = 1'b0;
    endtask

    task automatic rd(input string name, input int ry, input int exp);
        RY = AW'(ry);
        step();
        chk(name, int'(busY), exp);
    endtask

    // Holds a DataIn write to R4 and scrambles RX/RY/RW while the multiply runs;
    // returns the number of sampled Busy cycles. Leaves WEN low in the Done cycle.
    task automatic hold_busy(output int nb);
        nb = 0;
        for (int i = 0; i < 4 * W; i++) begin
            nb += int'(Busy);
            if (!mbusy) break;
            WEN = 1'b1; Sel = 1'b0; RW = 3'd4; DataIn = 8'h77;
            RX = AW'($urandom_range(0, N - 1));
            RY = AW'($urandom_range(0, N - 1));
            step();
        end
        WEN = 1'b0;
        chk("mul_timeout", int'(mbusy), 0);
    endtask

    int ops  [10] = '{2, 3, 4, 5, 12, 13, 8, 7, 0, 1};
    int exps [10] = '{8'h00, 8'hFF, 8'hFF, 8'h0F, 0, 1, 8'hE0, 8'h0F, 8'hFF, 8'hE1};

    initial begin
        int nb;
        bit done_seen;
        model_reset();
        #2 Rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(Busy), 0);
        chk("rst_done", int'(Done), 0);
        chk("rst_carry", int'(Carry), 0);
        @(posedge Clk);
        #1 Rst_n = 1'b1;
        compare_all();

        // basic write/read, R0 stays zero
        wr(1, 8'h03);
        rd("r1_datain", 1, 8'h03);
        wr(0, 8'h55);
        rd("r0_zero", 0, 8'h00);

        // ADD with carry-out, then SUB with borrow
        wr(1, 8'hFF); wr(2, 8'h01);
        alu(3, 1, 2, 0);
        rd("add_r3", 3, 8'h00);
        chk("add_carry", int'(Carry), 1);
        alu(4, 2, 1, 1);
        rd("sub_r4", 4, 8'h02);
        chk("sub_carry", int'(Carry), 1);
        wr(7, 8'h12);
        chk("carry_hold", int'(Carry), 1);

        // shifts and rotates
        wr(2, 8'h80);
        alu(5, 2, 0, 9);
        rd("sra_r5", 5, 8'hC0);
        alu(6, 2, 0, 11);
        rd("ror_r6", 6, 8'h40);
        wr(7, 8'h81);
        alu(7, 7, 0, 10);
        rd("rol_r7", 7, 8'h03);

        // logic/compare table on R1=0xF0, R2=0x0F
        wr(1, 8'hF0); wr(2, 8'h0F);
        for (int i = 0; i < 10; i++) begin
            alu(5, 1, 2, ops[i]);
            rd($sformatf("tbl_op%0d", ops[i]), 5, exps[i]);
        end
        alu(5, 1, 2, 15);
        rd("nop_r5", 5, 0);

        // model self-pin: product and ALU helpers against hand values
        chk("pin_sra", m_res(9, 8'h80, 0), 8'hC0);
        chk("pin_lt", m_res(13, 8'hF0, 8'h0F), 1);

        // MUL 3*5 into R3, then back-to-back 0x20*0x10 started in the Done cycle
        wr(1, 3); wr(2, 5); wr(4, 8'h02);
        wr(6, 8'h20); wr(7, 8'h10);
        alu(3, 1, 2, 14);
        hold_busy(nb);
        chk("mul1_busy_cycles", nb, MUL_EN ? W : 0);
        chk("mul1_done", int'(Done), int'(MUL_EN));
        RY = 3'd3;
        #1;
        chk("mul1_r3", int'(busY), MUL_EN ? 15 : 0);
        chk("mul1_carry", int'(Carry), 0);
        alu(3, 6, 7, 14);
        hold_busy(nb);
        chk("mul2_busy_cycles", nb, MUL_EN ? W : 0);
        rd("mul2_r3", 3, 8'h00);
        chk("mul2_carry", int'(Carry), MUL_EN ? 1 : 0);
        rd("mul_hold_r4", 4, 8'h02);

        // reset during the 4th cycle of a multiply
        wr(1, 3); wr(2, 5);
        alu(5, 1, 2, 14);
        step(); step(); step();
        #2 Rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("midrst_busy", int'(Busy), 0);
        step(); step();
        #2 Rst_n = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            step();
            done_seen |= Done;
        end
        chk("midrst_no_done", int'(done_seen), 0);
        for (int i = 0; i < N; i++) begin
            rd($sformatf("midrst_r%0d", i), i, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
